// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key codes, FSM encoding and the
// row/column to key-code mapping.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_NONE = 4'h0;
  localparam logic [3:0] KEY_ZERO = 4'hA;
  localparam logic [3:0] KEY_A    = 4'hB;
  localparam logic [3:0] KEY_B    = 4'hC;
  localparam logic [3:0] KEY_C    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Rows 0..2 carry digits 1..9 plus a letter in column 3; row 3 holds *, 0, # and
  // the null key, which is tracked but never reported.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = KEY_ZERO;
        2'd2:    code = KEY_HASH;
        default: code = KEY_NONE;
      endcase
    end else if (col == 2'd3) begin
      code = KEY_A + {2'b00, row};
    end else begin
      code = ({2'b00, row} << 1) + {2'b00, row} + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the asynchronous keypad column lines.
// Resets to the idle (all pulled-up) pattern so no phantom contact is seen.
module sync_2ff #(
  parameter int                WIDTH   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the rows, debounces a single-column contact and
// reports each accepted press as a one-cycle key code strobe.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SCAN     | drive current row, dwell SCAN_DIV cycles, then sample columns
// DEBOUNCE | row frozen, require latched column pattern to stay stable
// EMIT     | one cycle: register key code / strobe, raise key_held
// RELEASE  | row frozen, wait for all columns high for the debounce time
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] keypad,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] SCAN_TC = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       col_s;
  state_e           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       row_n_q, row_n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       pat_q, pat_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       keypad_q, keypad_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             single_low;
  logic [1:0]       low_idx;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_s)
  );

  // Saturating increment; the terminal compares below stop well before the top.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    single_low = 1'b1;
    low_idx    = 2'd0;
    case (col_s)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    col_d       = col_q;
    keypad_d    = KEY_NONE;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      SCAN: begin
        if (cnt_q >= SCAN_TC) begin
          cnt_d = '0;
          if (single_low) begin
            pat_d   = col_s;
            col_d   = low_idx;
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DEBOUNCE: begin
        if (col_s != pat_q) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_TC) begin
          state_d = EMIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      EMIT: begin
        keypad_d    = key_code(row_q, col_q);
        key_valid_d = (keypad_d != KEY_NONE);
        key_held_d  = 1'b1;
        state_d     = RELEASE;
        cnt_d       = '0;
      end
      RELEASE: begin
        if (col_s != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q >= DEB_TC) begin
          key_held_d = 1'b0;
          state_d    = SCAN;
          row_d      = row_q + 2'd1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d    = SCAN;
        row_d      = 2'd0;
        cnt_d      = '0;
        key_held_d = 1'b0;
      end
    endcase
    row_n_d = ~(4'b0001 << row_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      row_q       <= 2'd0;
      row_n_q     <= 4'b1110;
      cnt_q       <= '0;
      pat_q       <= 4'hF;
      col_q       <= 2'd0;
      keypad_q    <= KEY_NONE;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      row_n_q     <= row_n_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      col_q       <= col_d;
      keypad_q    <= keypad_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row_n     = row_n_q;
  assign keypad    = keypad_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model drives col_n from
// row_n, a monitor records strobes, and each scenario compares against expected codes.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  keypad;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys = '0;
  logic [3:0]  code_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hB,
                                 4'h4, 4'h5, 4'h6, 4'hC,
                                 4'h7, 4'h8, 4'h9, 4'hD,
                                 4'hE, 4'hA, 4'hF, 4'h0};

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [3:0]  got [$];
  int          incoherent = 0;
  int          b2b = 0;
  logic        prev_valid = 1'b0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB), .CNT_W(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .keypad    (keypad),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (key_valid) got.push_back(keypad);
      if (key_valid !== (keypad != 4'h0)) incoherent++;
      if (key_valid && prev_valid) b2b++;
    end
    prev_valid = key_valid;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int idx, input int hold, input int gap);
    keys[idx] = 1'b1;
    cycles(hold);
    keys = '0;
    cycles(gap);
  endtask

  task automatic test_reset();
    int bad;
    int k;
    logic [3:0] exp_row;
    bool_seen_dummy: begin end
    cycles(3);
    n_checks++;
    if (row_n !== 4'b1110 || keypad !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0)
      $display("FAIL reset_values: got row_n=%b keypad=%h valid=%b held=%b expected 1110 0 0 0",
               row_n, keypad, key_valid, key_held);
    else n_pass++;
    #1 rst = 1'b1;
    bad = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << (((k + 1) / SCAN_DIV) % 4));
      if (row_n !== exp_row) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL row_cycle: got %0d wrong row samples expected 0", bad);
    else n_pass++;
    keys[5] = 1'b1;
    k = 0;
    while (!key_held && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (key_held !== 1'b1) $display("FAIL held_before_reset: got %b expected 1", key_held);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (row_n !== 4'b1110) $display("FAIL midrun_row_n: got %b expected 1110", row_n);
    else n_pass++;
    n_checks++;
    if (keypad !== 4'h0 || key_valid !== 1'b0)
      $display("FAIL midrun_strobe: got keypad=%h valid=%b expected 0 0", keypad, key_valid);
    else n_pass++;
    n_checks++;
    if (key_held !== 1'b0) $display("FAIL midrun_held: got %b expected 0", key_held);
    else n_pass++;
    keys = '0;
    cycles(3);
    #1 rst = 1'b1;
    cycles(20);
  endtask

  task automatic test_single_5();
    int n;
    got.delete();
    keys[5] = 1'b1;
    cycles(60);
    n_checks++;
    if (key_held !== 1'b1) $display("FAIL held_during_5: got %b expected 1", key_held);
    else n_pass++;
    keys = '0;
    n = 0;
    while (key_held && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n < DEB || n > DEB + 4)
      $display("FAIL release_delay: got %0d cycles expected %0d..%0d", n, DEB, DEB + 4);
    else n_pass++;
    cycles(10);
    n_checks++;
    if (got.size() != 1) $display("FAIL count_5: got %0d strobes expected 1", got.size());
    else n_pass++;
    n_checks++;
    if (got.size() == 0 || got[0] !== 4'h5)
      $display("FAIL code_5: got %h expected 5", (got.size() > 0) ? got[0] : 4'hx);
    else n_pass++;
  endtask

  task automatic test_bounce_8();
    got.delete();
    for (int i = 0; i < 10; i++) begin
      keys[9] = ~keys[9];
      cycles(3);
    end
    keys[9] = 1'b1;
    cycles(60);
    keys = '0;
    cycles(30);
    n_checks++;
    if (got.size() != 1 || got[0] !== 4'h8)
      $display("FAIL bounce_8: got %0d strobes first %h expected 1 strobe of 8",
               got.size(), (got.size() > 0) ? got[0] : 4'hx);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int order [4] = '{0, 1, 2, 4};
    got.delete();
    for (int i = 0; i < 4; i++) tap(order[i], 60, 30);
    n_checks++;
    if (got.size() != 4) $display("FAIL seq_count: got %0d strobes expected 4", got.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== code_tbl[order[i]])
        $display("FAIL seq_code_%0d: got %h expected %h", i,
                 (i < got.size()) ? got[i] : 4'hx, code_tbl[order[i]]);
      else n_pass++;
    end
  endtask

  task automatic test_multikey();
    got.delete();
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    cycles(60);
    n_checks++;
    if (got.size() != 0 || key_held !== 1'b0)
      $display("FAIL two_keys: got %0d strobes held=%b expected 0 strobes held=0", got.size(), key_held);
    else n_pass++;
    keys = '0;
    cycles(30);
    tap(14, 60, 30);
    n_checks++;
    if (got.size() != 1 || got[0] !== 4'hF)
      $display("FAIL hash: got %0d strobes first %h expected 1 strobe of f",
               got.size(), (got.size() > 0) ? got[0] : 4'hx);
    else n_pass++;
    keys[15] = 1'b1;
    cycles(60);
    n_checks++;
    if (got.size() != 1 || key_held !== 1'b1)
      $display("FAIL null_key: got %0d strobes held=%b expected 1 strobe held=1", got.size(), key_held);
    else n_pass++;
    keys = '0;
    cycles(30);
    n_checks++;
    if (key_held !== 1'b0) $display("FAIL null_release: got held=%b expected 0", key_held);
    else n_pass++;
  endtask

  task automatic test_reset_debounce();
    int n;
    got.delete();
    keys[8] = 1'b1;
    n = 0;
    while (row_n == 4'b1011 && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (row_n != 4'b1011 && n < 80) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (row_n !== 4'b1011) $display("FAIL row2_reach: got row_n=%b expected 1011", row_n);
    else n_pass++;
    cycles(6);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (key_valid !== 1'b0 || key_held !== 1'b0 || row_n !== 4'b1110)
      $display("FAIL debounce_reset: got valid=%b held=%b row_n=%b expected 0 0 1110",
               key_valid, key_held, row_n);
    else n_pass++;
    keys = '0;
    cycles(2);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (row_n !== 4'b1110) $display("FAIL resume_row0: got %b expected 1110", row_n);
    else n_pass++;
    cycles(60);
    n_checks++;
    if (got.size() != 0) $display("FAIL no_strobe_7: got %0d strobes expected 0", got.size());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] exp_q [$];
    int idx;
    int bad;
    got.delete();
    for (int i = 0; i < 12; i++) begin
      idx = $urandom_range(0, 15);
      if (code_tbl[idx] != 4'h0) exp_q.push_back(code_tbl[idx]);
      tap(idx, 50 + $urandom_range(0, 20), 25 + $urandom_range(0, 15));
    end
    n_checks++;
    if (got.size() != exp_q.size())
      $display("FAIL rand_count: got %0d strobes expected %0d", got.size(), exp_q.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL rand_codes: got %0d wrong codes expected 0", bad);
    else n_pass++;
    n_checks++;
    if (b2b != 0 || incoherent != 0)
      $display("FAIL strobe_shape: got b2b=%0d incoherent=%0d expected 0 0", b2b, incoherent);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_5();
    test_bounce_8();
    test_back_to_back();
    test_multikey();
    test_reset_debounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
